// File: rtl/uart_matrix_loader.sv
// UART 8N1 receiver that fills a ROW x COLUMN byte matrix and exposes three read ports.
// Optional macro UART_LOADER_FRAME_CHECK_EN discards frames whose stop bit samples low.
module uart_matrix_loader #(
   parameter int unsigned ROW    = 2,
   parameter int unsigned COLUMN = 2,
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_data,
   input  logic       write_en,
   input  logic       read,
   input  logic [7:0] read_address0,
   input  logic [7:0] read_address1,
   input  logic [7:0] read_address2,
   output logic       written_completed,
   output logic [7:0] data0,
   output logic [7:0] data1,
   output logic [7:0] data2
);

   localparam int unsigned DEPTH   = ROW * COLUMN;
   localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 8);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned BW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Oversample tick generator: one pulse every DIV cycles
   logic [BW-1:0] baud_cnt;
   logic          tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt <= '0;
         tick     <= 1'b0;
      end else if (baud_cnt == BW'(DIV - 1)) begin
         baud_cnt <= '0;
         tick     <= 1'b1;
      end else begin
         baud_cnt <= baud_cnt + BW'(1);
         tick     <= 1'b0;
      end
   end

   // Receiver: start confirmed after 4 low ticks, then one sample per 8 ticks
   typedef enum logic {RX_IDLE, RX_FRAME} rx_state_t;

   rx_state_t  rx_state;
   logic       rx_meta, rx_sync;
   logic [2:0] low_cnt;
   logic [2:0] os_cnt;
   logic [3:0] bit_idx;
   logic [8:0] shift;
   logic       rx_status;
   logic       frame_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta     <= 1'b1;
         rx_sync     <= 1'b1;
         rx_state    <= RX_IDLE;
         low_cnt     <= '0;
         os_cnt      <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         rx_status   <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         rx_meta     <= rx_data;
         rx_sync     <= rx_meta;
         frame_valid <= 1'b0;
         if (tick) begin
            case (rx_state)
               RX_IDLE: begin
                  if (rx_sync) begin
                     low_cnt <= '0;
                  end else if (low_cnt == 3'd3) begin
                     rx_state  <= RX_FRAME;
                     rx_status <= 1'b1;
                     low_cnt   <= '0;
                     os_cnt    <= '0;
                     bit_idx   <= '0;
                     shift     <= '0;
                  end else begin
                     low_cnt <= low_cnt + 3'd1;
                  end
               end
               RX_FRAME: begin
                  os_cnt <= os_cnt + 3'd1;
                  if (os_cnt == 3'd7) begin
                     shift <= {rx_sync, shift[8:1]};
                     if (bit_idx == 4'd8) begin
                        rx_state    <= RX_IDLE;
                        rx_status   <= 1'b0;
                        frame_valid <= 1'b1;
                     end else begin
                        bit_idx <= bit_idx + 4'd1;
                     end
                  end
               end
               default: rx_state <= RX_IDLE;
            endcase
         end
      end
   end

   // Completed frame held stable for the STORE cycle
   logic [7:0] data_q;
`ifdef UART_LOADER_FRAME_CHECK_EN
   logic stop_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
`ifdef UART_LOADER_FRAME_CHECK_EN
         stop_q <= 1'b0;
`endif
      end else if (frame_valid) begin
         data_q <= shift[7:0];
`ifdef UART_LOADER_FRAME_CHECK_EN
         stop_q <= shift[8];
`endif
      end
   end

   logic store_ok;
`ifdef UART_LOADER_FRAME_CHECK_EN
   assign store_ok = write_en & stop_q;
`else
   assign store_ok = write_en;
`endif

   // Load FSM and matrix memory
   typedef enum logic [1:0] {IDLE, RECEIVING, STORE, END} state_t;

   state_t     state;
   logic [7:0] count;
   logic [7:0] mem [DEPTH];
   logic       last;

   assign last = ({1'b0, count} >= 9'(DEPTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         count             <= '0;
         written_completed <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         case (state)
            IDLE:      if (rx_status && write_en) state <= RECEIVING;
            RECEIVING: if (!rx_status) state <= STORE;
            STORE: begin
               if (store_ok) begin
                  mem[count[AW-1:0]] <= data_q;
                  count              <= count + 8'd1;
                  written_completed  <= last;
                  state              <= last ? END : IDLE;
               end else begin
                  state <= IDLE;
               end
            end
            END:     written_completed <= 1'b1;
            default: state <= IDLE;
         endcase
      end
   end

   function automatic logic [7:0] rd_mem(input logic [7:0] a);
      return ({1'b0, a} < 9'(DEPTH)) ? mem[a[AW-1:0]] : 8'h00;
   endfunction

   // Registered read ports, hold when read is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data0 <= '0;
         data1 <= '0;
         data2 <= '0;
      end else if (read) begin
         data0 <= rd_mem(read_address0);
         data1 <= rd_mem(read_address1);
         data2 <= rd_mem(read_address2);
      end
   end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Directed bench for uart_matrix_loader at DIV=2 (16 clk per bit) with a read-result scoreboard.
module tb_uart_matrix_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_data;
   logic       write_en;
   logic       read;
   logic [7:0] ra0, ra1, ra2;
   logic       written_completed;
   logic [7:0] d0, d1, d2;

   int n_tests = 0;
   int n_fail  = 0;
   logic [23:0] sb[$];

   always #5 clk = ~clk;

   uart_matrix_loader #(
      .ROW(2), .COLUMN(2), .CLK_HZ(1_600_000), .BAUD(100_000)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .write_en(write_en), .read(read),
      .read_address0(ra0), .read_address1(ra1), .read_address2(ra2),
      .written_completed(written_completed), .data0(d0), .data1(d1), .data2(d2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop, input int nbits);
      rx_data = 1'b0;
      step(16);
      for (int i = 0; i < nbits; i++) begin
         rx_data = b[i];
         step(16);
      end
      if (nbits == 8) begin
         rx_data = stop;
         step(16);
         rx_data = 1'b1;
         step(24);
      end
   endtask

   task automatic rd(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                     input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                     input string tag);
      logic [23:0] exp;
      sb.push_back({e0, e1, e2});
      ra0 = a0; ra1 = a1; ra2 = a2;
      read = 1'b1;
      step(1);
      read = 1'b0;
      exp = sb.pop_front();
      check({tag, ".data0"}, 32'(d0), 32'(exp[23:16]));
      check({tag, ".data1"}, 32'(d1), 32'(exp[15:8]));
      check({tag, ".data2"}, 32'(d2), 32'(exp[7:0]));
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      rx_data = 1'b1;
      step(3);
      rst = 1'b0;
      step(4);
   endtask

   initial begin
      rst = 1'b1; rx_data = 1'b1; write_en = 1'b0; read = 1'b0;
      ra0 = '0; ra1 = '0; ra2 = '0;
      step(3);
      check("reset.wc", 32'(written_completed), 32'd0);
      check("reset.d0", 32'(d0), 32'd0);
      check("reset.d1", 32'(d1), 32'd0);
      check("reset.d2", 32'(d2), 32'd0);
      check("reset.count", 32'(dut.count), 32'd0);
      rst = 1'b0;
      step(4);

      // Frame ignored while write_en is low
      send(8'hAA, 1'b1, 8);
      check("we0.count", 32'(dut.count), 32'd0);
      rd(8'd0, 8'd1, 8'd2, 8'h00, 8'h00, 8'h00, "we0");
      write_en = 1'b1;
      send(8'h5A, 1'b1, 8);
      check("we1.count", 32'(dut.count), 32'd1);
      rd(8'd0, 8'd1, 8'd2, 8'h5A, 8'h00, 8'h00, "we1");

      // Short low glitch must not start a frame
      rx_data = 1'b0;
      step(2);
      rx_data = 1'b1;
      step(200);
      check("glitch.count", 32'(dut.count), 32'd1);
      check("glitch.rx_status", 32'(dut.rx_status), 32'd0);

      // Reset in the middle of a frame, then a clean resend
      pulse_reset();
      send(8'h3C, 1'b1, 3);
      rst = 1'b1;
      rx_data = 1'b1;
      step(2);
      rst = 1'b0;
      step(40);
      check("midrst.count0", 32'(dut.count), 32'd0);
      send(8'h3C, 1'b1, 8);
      check("midrst.count1", 32'(dut.count), 32'd1);
      rd(8'd0, 8'd1, 8'd2, 8'h3C, 8'h00, 8'h00, "midrst");

      // Full load
      pulse_reset();
      send(8'h11, 1'b1, 8);
      send(8'h22, 1'b1, 8);
      send(8'h33, 1'b1, 8);
      check("load3.wc", 32'(written_completed), 32'd0);
      send(8'h44, 1'b1, 8);
      check("load4.wc", 32'(written_completed), 32'd1);
      check("load4.count", 32'(dut.count), 32'd4);
      rd(8'd0, 8'd1, 8'd2, 8'h11, 8'h22, 8'h33, "load.rd012");
      rd(8'd3, 8'd7, 8'd255, 8'h44, 8'h00, 8'h00, "load.rd3_7_255");

      // Frames after END are ignored
      send(8'hFF, 1'b1, 8);
      check("end.wc", 32'(written_completed), 32'd1);
      check("end.count", 32'(dut.count), 32'd4);
      rd(8'd3, 8'd0, 8'd1, 8'h44, 8'h11, 8'h22, "end.rd");

      // Reset clears everything
      rst = 1'b1;
      step(2);
      check("rst2.wc", 32'(written_completed), 32'd0);
      check("rst2.d0", 32'(d0), 32'd0);
      rst = 1'b0;
      step(4);
      rd(8'd0, 8'd1, 8'd3, 8'h00, 8'h00, 8'h00, "rst2.mem");

      // Frame with a bad stop bit
      send(8'h77, 1'b0, 8);
`ifdef UART_LOADER_FRAME_CHECK_EN
      check("badstop.count", 32'(dut.count), 32'd0);
      rd(8'd0, 8'd1, 8'd2, 8'h00, 8'h00, 8'h00, "badstop");
`else
      check("badstop.count", 32'(dut.count), 32'd1);
      rd(8'd0, 8'd1, 8'd2, 8'h77, 8'h00, 8'h00, "badstop");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
